// File: rtl/perf_csr_reader_pkg.sv
// perf_pkg: CSR addresses, decode types and FSM states shared by the perf counter read path
package perf_pkg;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    typedef enum logic [2:0] {SEL_NONE, SEL_CY_LO, SEL_CY_HI, SEL_IR_LO, SEL_IR_HI} perf_sel_e;
    typedef struct packed {
        perf_sel_e sel;
        logic      is_user_alias;
    } perf_dec_t;
    typedef enum logic {ST_IDLE, ST_RESP} perf_state_e;
endpackage

// File: rtl/perf_csr_reader_if.sv
// perf_csr_reader_if: CSR read request/response channel between the EXU CSR stage and the perf reader
//   master (EXU): drives rd_req_valid, rd_req_addr, rd_rsp_ready
//   slave (reader): drives rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err
interface perf_csr_reader_if;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [11:0] rd_req_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [31:0] rd_rsp_data;
    logic        rd_rsp_err;
    modport master (output rd_req_valid, rd_req_addr, rd_rsp_ready,
                    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err);
    modport slave  (input  rd_req_valid, rd_req_addr, rd_rsp_ready,
                    output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err);
endinterface

// File: rtl/perf_csr_reader_decode.sv
// perf_csr_decode: maps a CSR address plus privilege/enable state to a counter select and an error flag
//   addr_i       CSR address
//   user_mode_i  request issued from U-mode
//   cy_en_i      mcounteren.CY
//   ir_en_i      mcounteren.IR
//   dec_o        counter/half select and alias flag
//   err_o        illegal access (unmapped or not permitted)
module perf_csr_decode
    import perf_pkg::*;
(
    input  logic [11:0] addr_i,
    input  logic        user_mode_i,
    input  logic        cy_en_i,
    input  logic        ir_en_i,
    output perf_dec_t   dec_o,
    output logic        err_o
);
    perf_sel_e sel;
    logic      alias_c;
    logic      is_cy;
    logic      is_ir;
    always_comb begin
        sel = (addr_i == CSR_MCYCLE    || addr_i == CSR_CYCLE)    ? SEL_CY_LO :
              (addr_i == CSR_MCYCLEH   || addr_i == CSR_CYCLEH)   ? SEL_CY_HI :
              (addr_i == CSR_MINSTRET  || addr_i == CSR_INSTRET)  ? SEL_IR_LO :
              (addr_i == CSR_MINSTRETH || addr_i == CSR_INSTRETH) ? SEL_IR_HI : SEL_NONE;
        alias_c = addr_i[11:8] == 4'hC;
        is_cy   = sel == SEL_CY_LO || sel == SEL_CY_HI;
        is_ir   = sel == SEL_IR_LO || sel == SEL_IR_HI;
        // machine mode may read every mapped address; U-mode only the gated user aliases
        err_o   = sel == SEL_NONE ||
                  (user_mode_i && (!alias_c || (is_cy && !cy_en_i) || (is_ir && !ir_en_i)));
        dec_o   = '{sel: sel, is_user_alias: alias_c};
    end
endmodule

// File: rtl/perf_csr_reader.sv
// perf_csr_reader: read-side responder for mcycle/minstret returning RV32 halves with one cycle latency
//   clk, rst     core clock, asynchronous active-high reset
//   bus          CSR read channel (slave side)
//   user_mode    request issued from U-mode
//   mcounteren   bit0 CY, bit2 IR enables for U-mode aliases
//   mcycle_q     live cycle counter
//   minstret_q   live instret counter
// Optional: define PERF_SNAPSHOT_EN so a low-half read freezes the matching high half for the next high read.
module perf_csr_reader
    import perf_pkg::*;
#(
    parameter int CNT_WIDTH  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    perf_csr_reader_if.slave     bus,
    input  logic                 user_mode,
    input  logic [2:0]           mcounteren,
    input  logic [CNT_WIDTH-1:0] mcycle_q,
    input  logic [CNT_WIDTH-1:0] minstret_q
);
    perf_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    perf_dec_t             dec;
    logic                  dec_err;
    logic                  accept;
    logic [63:0]           cy_w, ir_w;
    logic [31:0]           cy_hi, ir_hi, rd_val;
    logic                  unused_ok;
    // narrower counters zero-extend, wider ones drop bits above 63
    assign cy_w      = 64'(mcycle_q);
    assign ir_w      = 64'(minstret_q);
    assign unused_ok = &{1'b0, mcounteren[1]};
    perf_csr_decode u_dec (
        .addr_i      (bus.rd_req_addr),
        .user_mode_i (user_mode),
        .cy_en_i     (mcounteren[0]),
        .ir_en_i     (mcounteren[2]),
        .dec_o       (dec),
        .err_o       (dec_err)
    );
    assign bus.rd_req_ready = state_q == ST_IDLE || bus.rd_rsp_ready;
    assign accept           = bus.rd_req_valid && bus.rd_req_ready;
`ifdef PERF_SNAPSHOT_EN
    logic [31:0] cy_sh_q, ir_sh_q;
    logic        cy_fl_q, ir_fl_q;
    assign cy_hi = cy_fl_q ? cy_sh_q : cy_w[63:32];
    assign ir_hi = ir_fl_q ? ir_sh_q : ir_w[63:32];
    // only successful reads move the shadows; errored reads leave them untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cy_sh_q <= '0;
            ir_sh_q <= '0;
            cy_fl_q <= 1'b0;
            ir_fl_q <= 1'b0;
        end else if (accept && !dec_err) begin
            if (dec.sel == SEL_CY_LO) begin
                cy_sh_q <= cy_w[63:32];
                cy_fl_q <= 1'b1;
            end
            if (dec.sel == SEL_CY_HI) cy_fl_q <= 1'b0;
            if (dec.sel == SEL_IR_LO) begin
                ir_sh_q <= ir_w[63:32];
                ir_fl_q <= 1'b1;
            end
            if (dec.sel == SEL_IR_HI) ir_fl_q <= 1'b0;
        end
    end
`else
    assign cy_hi = cy_w[63:32];
    assign ir_hi = ir_w[63:32];
`endif
    always_comb begin
        rd_val  = dec_err                 ? 32'h0       :
                  dec.sel == SEL_CY_LO    ? cy_w[31:0]  :
                  dec.sel == SEL_CY_HI    ? cy_hi       :
                  dec.sel == SEL_IR_LO    ? ir_w[31:0]  :
                  dec.sel == SEL_IR_HI    ? ir_hi       : 32'h0;
        state_d = accept ? ST_RESP :
                  (state_q == ST_RESP && !bus.rd_rsp_ready) ? ST_RESP : ST_IDLE;
        data_d  = accept ? DATA_WIDTH'(rd_val) : data_q;
        err_d   = accept ? dec_err : err_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    assign bus.rd_rsp_valid = state_q == ST_RESP;
    assign bus.rd_rsp_data  = 32'(data_q);
    assign bus.rd_rsp_err   = err_q;
endmodule
